// File: rtl/simple_pkg.sv
// Shared constants, opcode fields and run-state type for the multi-cycle core sequencer.
package simple_pkg;

  localparam int PH_IF = 0;
  localparam int PH_ID = 1;
  localparam int PH_EX = 2;
  localparam int PH_WB = 3;
  localparam int PH_PC = 4;

  localparam logic [1:0] OPC_LD  = 2'b00;
  localparam logic [1:0] OPC_ST  = 2'b01;
  localparam logic [1:0] OPC_BR  = 2'b10;
  localparam logic [1:0] OPC_ALU = 2'b11;

  localparam logic [3:0] OP3_HLT  = 4'b1111;
  localparam logic [3:0] OP3_CMP  = 4'b0101;
  localparam logic [3:0] OP3_OUT  = 4'b1101;
  localparam logic [3:0] OP3_1110 = 4'b1110;

  localparam logic [4:0] LI_PREFIX = 5'b10000;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    HALT
  } run_state_t;

  // True when exactly one bit is set; zero and multi-hot both count as illegal.
  function automatic logic is_one_hot(input logic [4:0] v);
    return (v != 5'b00000) && ((v & (v - 5'd1)) == 5'b00000);
  endfunction

endpackage

// File: rtl/phase_ctrl_if.sv
// Control/status bundle between the phase sequencer and the rest of the core.
interface phase_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             stop;
  logic [15:0]      instr;
  logic             mem_wait;
  logic [4:0]       phase;
  logic             ir_load;
  logic             pc_load;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output run, stop, instr, mem_wait,
    input  phase, ir_load, pc_load, running, halted, retired_count
  );

  modport slave (
    input  run, stop, instr, mem_wait,
    output phase, ir_load, pc_load, running, halted, retired_count
  );
endinterface

// File: rtl/phase_ctrl_instr_class.sv
// Combinational instruction classifier; also feeds the writeback enable logic.
module instr_class
  import simple_pkg::*;
(
  input  logic [15:0] instr,
  output logic        is_mem,
  output logic        is_hlt,
  output logic        is_skip
);

  logic [1:0] opc;
  logic [3:0] op3;
  logic       unused_bits;

  assign opc = instr[15:14];
  assign op3 = instr[7:4];

  assign is_mem = (opc == OPC_LD) || (opc == OPC_ST);
  assign is_hlt = (opc == OPC_ALU) && (op3 == OP3_HLT);

  // Instructions that neither touch memory nor write the register file.
  assign is_skip = ((opc == OPC_ALU) &&
                    ((op3 == OP3_CMP) || (op3 == OP3_OUT) ||
                     (op3 == OP3_1110) || (op3 == OP3_HLT))) ||
                   ((opc == OPC_BR) && (instr[15:11] != LI_PREFIX));

  assign unused_bits = &{1'b0, instr[10:8], instr[3:0]};

endmodule

// File: rtl/phase_ctrl.sv
// One-hot phase sequencer with run/stop/halt control and retired-instruction counter.
// Optional macro PHASE_SKIP_EN lets non-memory, non-writeback instructions skip phase[3].
module phase_ctrl
  import simple_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  phase_ctrl_if.slave  bus
);

  run_state_t       state_q;
  run_state_t       state_d;
  logic [4:0]       phase_q;
  logic [4:0]       phase_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             is_mem;
  logic             is_hlt;
  logic             is_skip;
  logic             skip_wb;

  instr_class u_class (
    .instr   (bus.instr),
    .is_mem  (is_mem),
    .is_hlt  (is_hlt),
    .is_skip (is_skip)
  );

`ifdef PHASE_SKIP_EN
  assign skip_wb = is_skip;
`else
  logic unused_skip;
  assign skip_wb     = 1'b0;
  assign unused_skip = is_skip;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STOP;
      phase_q   <= 5'b00000;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // stop is only honoured at the end of phase[4], and HLT beats it there.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    retire  = 1'b0;
    case (state_q)
      STOP: begin
        phase_d = 5'b00000;
        if (bus.run && !bus.stop) begin
          state_d = RUN;
          phase_d = 5'b00001;
        end
      end
      RUN: begin
        if (!is_one_hot(phase_q)) begin
          phase_d = 5'b00001;
        end else if (phase_q[PH_IF]) begin
          if (!bus.mem_wait) phase_d = 5'b00010;
        end else if (phase_q[PH_ID]) begin
          phase_d = 5'b00100;
        end else if (phase_q[PH_EX]) begin
          phase_d = skip_wb ? 5'b10000 : 5'b01000;
        end else if (phase_q[PH_WB]) begin
          if (!(is_mem && bus.mem_wait)) phase_d = 5'b10000;
        end else begin
          retire = 1'b1;
          if (is_hlt) begin
            state_d = HALT;
            phase_d = 5'b00000;
          end else if (bus.stop) begin
            state_d = STOP;
            phase_d = 5'b00000;
          end else begin
            phase_d = 5'b00001;
          end
        end
      end
      HALT: begin
        phase_d = 5'b00000;
      end
      default: begin
        state_d = STOP;
        phase_d = 5'b00000;
      end
    endcase
  end

  assign bus.phase         = phase_q;
  assign bus.ir_load       = phase_q[PH_IF] & ~bus.mem_wait;
  assign bus.pc_load       = phase_q[PH_PC];
  assign bus.running       = (state_q == RUN);
  assign bus.halted        = (state_q == HALT);
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_phase_ctrl.sv
// Scoreboard bench for phase_ctrl: instruction-level reference model queues expected per-cycle outputs.
`timescale 1ns/1ps
module tb_phase_ctrl;

  localparam int CNT_W  = 6;
  localparam int M_RUN  = 0;
  localparam int M_STOP = 1;
  localparam int M_HALT = 2;

  typedef struct packed {
    logic [4:0]       phase;
    logic             ir_load;
    logic             pc_load;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] count;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_ctrl_if #(.CNT_W(CNT_W)) bus ();

  phase_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  obs_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] model_count;
  int               mode;

  function automatic logic isMem(input logic [15:0] ins);
    return ins[15:14] == 2'b00 || ins[15:14] == 2'b01;
  endfunction

  function automatic logic isHlt(input logic [15:0] ins);
    return ins[15:14] == 2'b11 && ins[7:4] == 4'hF;
  endfunction

  function automatic logic skips(input logic [15:0] ins);
`ifdef PHASE_SKIP_EN
    return (ins[15:14] == 2'b11 && (ins[7:4] == 4'h5 || ins[7:4] == 4'hD ||
                                    ins[7:4] == 4'hE || ins[7:4] == 4'hF)) ||
           (ins[15:14] == 2'b10 && ins[15:11] != 5'b10000);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] randInstr(input logic allow_hlt);
    logic [15:0] ins;
    ins = 16'($urandom);
    if (!allow_hlt && isHlt(ins)) ins[4] = 1'b0;
    return ins;
  endfunction

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a.phase   = bus.phase;
    a.ir_load = bus.ir_load;
    a.pc_load = bus.pc_load;
    a.running = bus.running;
    a.halted  = bus.halted;
    a.count   = bus.retired_count;
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t got phase=%b ir=%b pc=%b run=%b halt=%b cnt=%0d, expected phase=%b ir=%b pc=%b run=%b halt=%b cnt=%0d",
               $time, a.phase, a.ir_load, a.pc_load, a.running, a.halted, a.count,
               e.phase, e.ir_load, e.pc_load, e.running, e.halted, e.count);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must show during that cycle.
  task automatic applyStimulus(input logic chk, input logic r, input logic rn, input logic st,
                               input logic [15:0] ins, input logic mw,
                               input logic [4:0] ph, input logic running, input logic halted);
    @(posedge clk);
    #1;
    rst          = r;
    bus.run      = rn;
    bus.stop     = st;
    bus.instr    = ins;
    bus.mem_wait = mw;
    if (chk) begin
      obs_t e;
      e.phase   = ph;
      e.ir_load = ph[0] & ~mw;
      e.pc_load = ph[4];
      e.running = running;
      e.halted  = halted;
      e.count   = model_count;
      exp_q.push_back(e);
    end
  endtask

  task automatic runInstr(input logic [15:0] ins, input int fs, input int ms, input logic st_end);
    for (int i = 0; i <= fs; i++)
      applyStimulus(1, 0, 1'($urandom), 1'($urandom), ins, (i < fs), 5'b00001, 1, 0);
    applyStimulus(1, 0, 1'($urandom), 1'($urandom), ins, 1'($urandom), 5'b00010, 1, 0);
    applyStimulus(1, 0, 1'($urandom), 1'($urandom), ins, 1'($urandom), 5'b00100, 1, 0);
    if (!skips(ins)) begin
      if (isMem(ins)) begin
        for (int j = 0; j <= ms; j++)
          applyStimulus(1, 0, 1'($urandom), 1'($urandom), ins, (j < ms), 5'b01000, 1, 0);
      end else begin
        applyStimulus(1, 0, 1'($urandom), 1'($urandom), ins,
                      (ms > 0) ? 1'b1 : 1'($urandom), 5'b01000, 1, 0);
      end
    end
    applyStimulus(1, 0, 1'($urandom), st_end, ins, 1'($urandom), 5'b10000, 1, 0);
    model_count = model_count + CNT_W'(1);
    if (isHlt(ins))  mode = M_HALT;
    else if (st_end) mode = M_STOP;
    else             mode = M_RUN;
  endtask

  task automatic stopCycles(input int n);
    logic rn;
    for (int i = 0; i < n - 1; i++) begin
      rn = 1'($urandom);
      applyStimulus(1, 0, rn, rn ? 1'b1 : 1'($urandom), randInstr(1), 1'($urandom), 5'b00000, 0, 0);
    end
    applyStimulus(1, 0, 1, 0, randInstr(1), 1'($urandom), 5'b00000, 0, 0);
    mode = M_RUN;
  endtask

  task automatic haltCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1, 0, 1, 1'($urandom), randInstr(1), 1'($urandom), 5'b00000, 0, 1);
  endtask

  task automatic resetDut();
    applyStimulus(1, 1, 1, 0, 16'h0000, 0, 5'b00000, 0, mode == M_HALT);
    model_count = '0;
    mode = M_STOP;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    rst          = 1'b1;
    bus.run      = 1'b0;
    bus.stop     = 1'b0;
    bus.instr    = 16'h0000;
    bus.mem_wait = 1'b0;
    model_count  = '0;
    mode         = M_STOP;

    applyStimulus(0, 1, 0, 0, 16'hC000, 0, 5'b00000, 0, 0);
    applyStimulus(1, 1, 0, 0, 16'hC000, 0, 5'b00000, 0, 0);

    stopCycles(1);
    runInstr(16'hC000, 0, 0, 0);
    runInstr(16'h0000, 0, 3, 0);
    runInstr(16'hC000, 0, 3, 0);
    runInstr(16'h4123, 2, 1, 0);
    runInstr(16'hC050, 0, 1, 0);
    runInstr(16'h8000, 0, 0, 0);
    runInstr(16'h8800, 1, 2, 0);
    runInstr(16'hC000, 0, 0, 1);
    stopCycles(4);
    runInstr(16'hC0D0, 0, 0, 0);
    runInstr(16'hC0F0, 0, 0, 1);
    haltCycles(4);
    resetDut();
    stopCycles(2);

    // Long halt-free stretch so the narrow counter wraps.
    for (int i = 0; i < 70; i++) begin
      runInstr(randInstr(0), $urandom_range(0, 2), $urandom_range(0, 3), 0);
    end

    for (int i = 0; i < 150; i++) begin
      if (mode == M_HALT) begin
        haltCycles($urandom_range(1, 3));
        resetDut();
      end
      if (mode == M_STOP) stopCycles($urandom_range(1, 3));
      runInstr(($urandom_range(0, 19) == 0) ? (16'hC0F0 | 16'($urandom_range(0, 15))) : randInstr(0),
               $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_ctrl.md
Name: phase_ctrl

Overview:
- Top-level sequencer for the 16-bit multi-cycle core.
- Generates the one-hot 5-bit phase vector consumed by every datapath stage: fetch, decode/register read, execute, memory+writeback, PC update.
- Handles run/stop control, memory wait stalls and HLT detection, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start/resume request; level, sampled each cycle.
- stop  in  1  pause request; level, sampled at the end of phase[4].
- instr  in  16  current instruction register contents; stable during phase[1]..phase[4].
- mem_wait  in  1  memory not ready; stalls phase[0] always, and stalls phase[3] for LD/ST only.
- phase  out  5  one-hot phase: [0] fetch, [1] decode, [2] execute, [3] mem/writeback, [4] PC update. All-zero when not running.
- ir_load  out  1  load the IR; high in phase[0] when mem_wait=0.
- pc_load  out  1  update the PC; high in phase[4].
- running  out  1  high in RUN.
- halted  out  1  high in HALT.
- retired_count  out  CNT_W  number of instructions completed (phase[4] exits); wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=STOP, phase=5'b00000, running=0, halted=0, retired_count=0, ir_load=0, pc_load=0. rst overrides all other inputs in the same cycle.
- States:
  - STOP: phase=0. run=1 and stop=0 → RUN, with phase=00001 on the next cycle. run and stop both high → remain in STOP (stop wins).
  - RUN: phase rotates left one bit per cycle.
    - Hold in phase[0] while mem_wait=1.
    - Hold in phase[3] while mem_wait=1 and the instruction is LD (instr[15:14]=00) or ST (instr[15:14]=01). mem_wait is ignored in phase[3] for all other instructions.
    - mem_wait is ignored in phase[1], phase[2] and phase[4].
  - End of phase[4] (this cycle):
    - retired_count increments.
    - If HLT (instr[15:14]=11 and instr[7:4]=1111) → HALT, phase=0.
    - Else if stop=1 → STOP, phase=0.
    - Else phase=00001.
  - HALT: phase=0, halted=1. run is ignored; only rst exits HALT.
- HLT takes precedence over stop at phase[4].
- stop asserted in any phase other than phase[4] has no effect until phase[4]. The current instruction always completes; no mid-instruction abort.
- Latency: resume from STOP to the first phase[0] is 1 cycle. Nominal instruction is 5 cycles, plus stall cycles.
- ir_load and pc_load are combinational from phase and mem_wait (Mealy); all other outputs are registered.
- phase is always either zero or exactly one-hot. Any illegal value detected (reachable only via X/upset) forces phase=00001 in RUN.
- retired_count wraps from 2^CNT_W−1 to 0 with no flag.

Optional Feature:
- Macro: PHASE_SKIP_EN.
- Defined: from phase[2], jump directly to phase[4] (skip phase[3]) for instructions that neither touch memory nor write the register file:
  - instr[15:14]=11 with instr[7:4] in {0101, 1101, 1110, 1111};
  - instr[15:14]=10 with instr[15:11]≠10000.
  - Such instructions take 4 cycles. mem_wait has no effect for them.
- Undefined: phase[3] is always visited; all instructions take 5 cycles plus stalls.

Decomposition:
- Shared package simple_pkg:
  - phase index constants (PH_IF=0 .. PH_PC=4);
  - opcode field constants (OPC_LD=2'b00, OPC_ST=2'b01, OPC_BR=2'b10, OPC_ALU=2'b11, OP3_HLT=4'b1111, OP3_CMP=4'b0101, OP3_OUT=4'b1101, OP3_1110=4'b1110, LI_PREFIX=5'b10000);
  - run-state enum {STOP, RUN, HALT}.
- One sub-module, instr_class: purely combinational, outputs is_mem, is_hlt, is_skip from instr. It is shared with the writeback enable logic.

Test Plan:
- Reset and start: rst for 2 cycles, then run=1 with instr=ALU ADD (0xC000) → phase sequence 00000, 00001, 00010, 00100, 01000, 10000, 00001; retired_count=1 after the first phase[4]; pc_load high only in phase[4].
- Memory stalls: instr=LD (0x0000), mem_wait=1 for 3 cycles in phase[3] → phase[3] held 4 cycles total. Same mem_wait pattern with instr=ADD → no hold.
- Halt: instr=0xC0F0 (HLT) → after phase[4], halted=1, phase=0, retired_count incremented. run=1 afterwards → stays halted until rst.
- Stop timing: stop=1 raised in phase[1] → instruction completes; STOP entered after phase[4]. run=1 → resumes at phase[0] next cycle. run=stop=1 in STOP → remains stopped.
- Wrap: preload retired_count via 65535 retirements (or force) → next retirement gives 0.
- PHASE_SKIP_EN defined: instr=0xC050 (CMP) → 00100 followed directly by 10000. instr=0x8000 (LI) → phase[3] still visited. Undefined: CMP takes 5 cycles.
